tinker_mem_responder: RTL and testbench
=======================================

Name: tinker_mem_responder

Overview:
Responder side of the core↔memory interface. It serves 32-bit instruction fetches, 64-bit data loads and 64-bit data stores from a byte-addressed, big-endian unified memory. Requests and responses use a valid/ready handshake with a fixed, parameterised access latency and one outstanding request at a time. It replaces the combinational memory model so that the multi-cycle tinker core can be built against a realistic responder.

Parameters:
MEM_SIZE, 524288, storage size in bytes; valid byte addresses are 0..MEM_SIZE-1.
LATENCY, 2, cycles from request acceptance to rsp_valid rising; legal range 1..15.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  responder can accept a request.
req_op  in  2  operation: 00 FETCH32, 01 LOAD64, 10 STORE64, 11 reserved.
req_addr  in  64  byte address of the first (most significant) byte.
req_wdata  in  64  store data; used only for STORE64.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_data  out  64  load data; FETCH32 result is zero-extended in [31:0]; 0 for stores and errors.
rsp_err  out  1  request was out of range or used the reserved op.

Behaviour:
- Storage: byte array named bytes[0:MEM_SIZE-1] lives in this module, so bench preload paths stay valid. Reset does not clear it.
- Byte order is big-endian: bytes[addr] holds the most significant byte. No alignment requirement.
- States: IDLE, BUSY, RESP.
- Reset (reset low) forces state IDLE, counter 0, req_ready 0, rsp_valid 0, rsp_data 0, rsp_err 0.
- req_ready = 1 only in IDLE with reset high.
- Acceptance happens on an edge where req_valid && req_ready. On acceptance, latch op, addr and wdata, load counter with LATENCY-1, and go to BUSY.
- BUSY: decrement the counter each edge. When the counter is 0, perform the access on that edge, register rsp_data and rsp_err, and go to RESP.
- Timing: rsp_valid rises exactly LATENCY edges after the acceptance edge.
- Store commit: a STORE64 writes bytes[a..a+7] on the same edge that enters RESP. Any later request observes the stored data.
- RESP: rsp_valid = 1. rsp_data and rsp_err stay stable until a handshake edge (rsp_valid && rsp_ready). On that edge, go to IDLE with rsp_valid 0 and rsp_data 0.
- Throughput: at most one request every LATENCY+2 cycles. A request cannot be accepted on the response-handshake edge.
- Range check uses 65-bit arithmetic, so there is no wrap-around. The request is an error if addr + size > MEM_SIZE (size 4 for FETCH32, 8 for LOAD64/STORE64).
- Error response: rsp_err = 1, rsp_data = 0, and no byte is written.
- Reserved op 11: always rsp_err = 1, no access.
- req_addr, req_op and req_wdata are sampled only at acceptance; changes during BUSY or RESP are ignored.
- req_valid may be held high across responses; each acceptance is a new request.
- Reset mid-operation: outstanding request is dropped and no response is produced. A store whose commit edge has already occurred stays written; one not yet committed never writes.
- Exactly one write port and one read per access; no partial-width stores.

Decomposition:
- Package tinker_mem_pkg:
  - enum mem_op_t {FETCH32=2'b00, LOAD64=2'b01, STORE64=2'b10, RSVD=2'b11}
  - enum resp_state_t {IDLE, BUSY, RESP}
  - localparams FETCH_BYTES=4, DATA_BYTES=8
- Single module; no sub-module. The byte array stays at top level of this block for hierarchical preload.

Test Plan:
1. Preload bytes[0x2000..0x2003]=8'h11,22,33,44; FETCH32 addr 0x2000 -> rsp_valid exactly 2 cycles after acceptance, rsp_data=64'h0000_0000_1122_3344, rsp_err=0.
2. STORE64 addr 0x10000 wdata 64'hDEAD_BEEF_0123_4567, then LOAD64 addr 0x10000 -> bytes[0x10000]=8'hDE, bytes[0x10007]=8'h67; load returns 64'hDEAD_BEEF_0123_4567.
3. LOAD64 addr MEM_SIZE-8 -> rsp_err=0. LOAD64 addr MEM_SIZE-7 -> rsp_err=1, rsp_data=0. STORE64 addr 64'hFFFF_FFFF_FFFF_FFFC -> rsp_err=1, memory unchanged (no wrap to 0).
4. Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_err stable, req_ready=0 throughout. Then rsp_ready=1 -> back to IDLE, next request accepted one cycle later.
5. Drive reset low one cycle after accepting STORE64 to addr 0x3000 (LATENCY=2) -> rsp_valid never asserts and bytes[0x3000..0x3007] keep their preload. After reset, req_ready=1.
6. req_op=2'b11, any in-range address -> rsp_err=1, rsp_data=0, no memory change. Repeat scenario 1 with LATENCY=1 and LATENCY=15 -> response latency matches.

Source files
------------

// File: rtl/tinker_mem_pkg.sv
// Shared types for the tinker memory responder.
// Operation codes, responder states and access sizes.
package tinker_mem_pkg;

  typedef enum logic [1:0] {
    FETCH32 = 2'b00,
    LOAD64  = 2'b01,
    STORE64 = 2'b10,
    RSVD    = 2'b11
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } resp_state_t;

  localparam int FETCH_BYTES = 4;
  localparam int DATA_BYTES  = 8;

endpackage

// File: rtl/tinker_mem_responder.sv
// Fixed-latency, one-outstanding memory responder for the tinker core.
// Big-endian unified byte store serving fetches, loads and stores.
module tinker_mem_responder
  import tinker_mem_pkg::*;
#(
  parameter int MEM_SIZE = 524288,
  parameter int LATENCY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_err
);

  localparam int AW = $clog2(MEM_SIZE);

  logic [7:0] bytes [0:MEM_SIZE-1];

  resp_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  mem_op_t     op_q, op_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] data_d;
  logic        err_d;
  logic        mem_we;
  logic        range_err;
  logic [64:0] end_addr;
  logic [AW-1:0] base;
  logic [63:0] rd_word;

  assign req_ready = reset && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  // 65-bit sum so huge addresses cannot wrap into range
  assign end_addr = {1'b0, addr_q}
                  + ((op_q == FETCH32) ? 65'(FETCH_BYTES)
                                       : 65'(DATA_BYTES));
  assign range_err = end_addr > 65'(MEM_SIZE);
  assign base = addr_q[AW-1:0];

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      rd_word[63-8*i -: 8] = bytes[base + AW'(i)];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = rsp_data;
    err_d   = rsp_err;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_d    = mem_op_t'(req_op);
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (op_q == RSVD || range_err) begin
            err_d  = 1'b1;
            data_d = '0;
          end else begin
            err_d = 1'b0;
            unique case (op_q)
              FETCH32: data_d = {32'd0, rd_word[63:32]};
              LOAD64:  data_d = rd_word;
              default: data_d = '0;
            endcase
            mem_we = reset && (op_q == STORE64);
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          data_d  = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= FETCH32;
      addr_q   <= '0;
      wdata_q  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rsp_data <= data_d;
      rsp_err  <= err_d;
    end
  end

  // Storage is not reset; the store commits on the edge entering RESP
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        bytes[base + AW'(i)] <= wdata_q[63-8*i -: 8];
      end
    end
  end

endmodule

// File: tb/tb_tinker_mem_responder.sv
// Bench for tinker_mem_responder: vector table, corner sequences,
// and randomized traffic against a byte-array reference model.
module tb_tinker_mem_responder;

  localparam int MEM = 524288;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;

  logic        l_req_valid, l_rsp_ready;
  logic [1:0]  l_req_op;
  logic [63:0] l_req_addr, l_req_wdata;
  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [63:0] a_rsp_data;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [63:0] b_rsp_data;

  int tests = 0;
  int fails = 0;

  logic [7:0] mdl [0:MEM-1];

  always #5 clk = ~clk;

  tinker_mem_responder #(.MEM_SIZE(MEM), .LATENCY(2)) u0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  tinker_mem_responder #(.MEM_SIZE(MEM), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset),
    .req_valid(l_req_valid), .req_ready(a_req_ready),
    .req_op(l_req_op), .req_addr(l_req_addr), .req_wdata(l_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(l_rsp_ready),
    .rsp_data(a_rsp_data), .rsp_err(a_rsp_err)
  );

  tinker_mem_responder #(.MEM_SIZE(MEM), .LATENCY(15)) u15 (
    .clk(clk), .reset(reset),
    .req_valid(l_req_valid), .req_ready(b_req_ready),
    .req_op(l_req_op), .req_addr(l_req_addr), .req_wdata(l_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(l_rsp_ready),
    .rsp_data(b_rsp_data), .rsp_err(b_rsp_err)
  );

  typedef struct {
    logic [1:0]  op;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic pl(input int a, input logic [7:0] v);
    u0.bytes[a]  = v;
    u1.bytes[a]  = v;
    u15.bytes[a] = v;
    mdl[a]       = v;
  endtask

  // Reference: range rule in 65-bit arithmetic, big-endian byte walk
  task automatic model(input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] wd,
                       output logic [63:0] d, output logic e);
    int sz = (op == 2'b00) ? 4 : 8;
    logic [64:0] endp = {1'b0, a} + 65'(sz);
    d = '0;
    e = 1'b0;
    if (op == 2'b11 || endp > 65'(MEM)) begin
      e = 1'b1;
    end else if (op == 2'b10) begin
      for (int i = 0; i < 8; i++)
        mdl[int'(a[31:0]) + i] = wd[63-8*i -: 8];
    end else begin
      for (int i = 0; i < sz; i++)
        d = (d << 8) | 64'(mdl[int'(a[31:0]) + i]);
    end
  endtask

  task automatic do_req(input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] wd,
                        output logic [63:0] d, output logic e,
                        output int lat);
    req_op = op;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1'b1;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    d = rsp_data;
    e = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_cleared", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] d, d0, md;
    logic e, e0, me, ok;
    int lat, na, nb;

    reset = 1'b0;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    l_req_valid = 1'b0; l_req_op = '0; l_req_addr = '0;
    l_req_wdata = '0; l_rsp_ready = 1'b0;

    for (int i = 0; i < 4096; i++) begin
      pl(i, 8'($urandom));
      pl(MEM - 4096 + i, 8'($urandom));
    end
    for (int i = 0; i < 8; i++) begin
      pl(i, 8'h50 + 8'(i));
      pl(MEM - 8 + i, 8'hA0 + 8'(i));
      pl('h3000 + i, 8'h70 + 8'(i));
    end
    pl('h2000, 8'h11); pl('h2001, 8'h22); pl('h2002, 8'h33);
    pl('h2003, 8'h44); pl('h2004, 8'h55); pl('h2005, 8'h66);
    pl('h2006, 8'h77); pl('h2007, 8'h88); pl('h2008, 8'h99);

    tv[0]  = '{2'b00, 64'h2000, 64'h0, 64'h1122_3344, 1'b0};
    tv[1]  = '{2'b10, 64'h10000, 64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0};
    tv[2]  = '{2'b01, 64'h10000, 64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0};
    tv[3]  = '{2'b01, 64'(MEM - 8), 64'h0, 64'hA0A1_A2A3_A4A5_A6A7, 1'b0};
    tv[4]  = '{2'b01, 64'(MEM - 7), 64'h0, 64'h0, 1'b1};
    tv[5]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1111_2222_3333_4444,
               64'h0, 1'b1};
    tv[6]  = '{2'b01, 64'h0, 64'h0, 64'h5051_5253_5455_5657, 1'b0};
    tv[7]  = '{2'b11, 64'h2000, 64'hCAFE_CAFE_CAFE_CAFE, 64'h0, 1'b1};
    tv[8]  = '{2'b00, 64'h2000, 64'h0, 64'h1122_3344, 1'b0};
    tv[9]  = '{2'b00, 64'(MEM - 4), 64'h0, 64'hA4A5_A6A7, 1'b0};
    tv[10] = '{2'b00, 64'(MEM - 3), 64'h0, 64'h0, 1'b1};
    tv[11] = '{2'b01, 64'h2001, 64'h0, 64'h2233_4455_6677_8899, 1'b0};

    @(posedge clk); #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_data", rsp_data, 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      model(tv[i].op, tv[i].addr, tv[i].wd, md, me);
      do_req(tv[i].op, tv[i].addr, tv[i].wd, d, e, lat);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_data", i), d, tv[i].exp_d);
      chk($sformatf("vec%0d_err", i), 64'(e), 64'(tv[i].exp_e));
    end
    chk("byte_10000", 64'(u0.bytes['h10000]), 64'hDE);
    chk("byte_10007", 64'(u0.bytes['h10007]), 64'h67);

    // Response held with rsp_ready low; request waiting behind it
    req_op = 2'b01; req_addr = 64'h10000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_lat", 64'(lat), 64'd2);
    d0 = rsp_data;
    e0 = rsp_err;
    chk("hold_data", d0, 64'hDEAD_BEEF_0123_4567);
    ok = 1'b1;
    req_op = 2'b00; req_addr = 64'h2000; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (rsp_data !== d0 || rsp_err !== e0 || rsp_valid !== 1'b1 ||
          req_ready !== 1'b0)
        ok = 1'b0;
    end
    chk("hold_stable", 64'(ok), 64'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("hs_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("hs_no_accept", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    chk("next_accepted", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("next_lat", 64'(lat), 64'd2);
    chk("next_data", rsp_data, 64'h1122_3344);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset between acceptance and store commit
    req_op = 2'b10; req_addr = 64'h3000;
    req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("rst_no_rsp", 64'(ok), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("rst_byte%0d", i), 64'(u0.bytes['h3000 + i]),
          64'(8'h70 + 8'(i)));
    @(posedge clk); #1;

    // Latency 1 and 15 instances
    l_req_op = 2'b00; l_req_addr = 64'h2000; l_req_valid = 1'b1;
    @(posedge clk); #1;
    l_req_valid = 1'b0;
    na = -1; nb = -1;
    for (int c = 1; c <= 40 && (na < 0 || nb < 0); c++) begin
      @(posedge clk); #1;
      if (na < 0 && a_rsp_valid) na = c;
      if (nb < 0 && b_rsp_valid) nb = c;
    end
    chk("lat1", 64'(na), 64'd1);
    chk("lat15", 64'(nb), 64'd15);
    chk("lat1_data", a_rsp_data, 64'h1122_3344);
    chk("lat15_data", b_rsp_data, 64'h1122_3344);
    l_rsp_ready = 1'b1;
    @(posedge clk); #1;
    l_rsp_ready = 1'b0;

    for (int n = 0; n < 300; n++) begin
      logic [1:0] op;
      logic [63:0] a, wd;
      op = 2'($urandom_range(0, 3));
      wd = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: a = 64'($urandom_range(0, 4088));
        1: a = 64'(MEM - 4096 + int'($urandom_range(0, 4100)));
        2: a = {$urandom, $urandom};
        default: a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
      endcase
      model(op, a, wd, md, me);
      do_req(op, a, wd, d, e, lat);
      chk("rand_lat", 64'(lat), 64'd2);
      chk("rand_data", d, md);
      chk("rand_err", 64'(e), 64'(me));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
